acc_layer_sequencer: RTL and testbench

- Parametrised top-level sequencer for the CNN accelerator. It replaces the fixed conv1/conv2/fullc controller with an N-layer chain.
- Runs NUM_LAYERS compute layers in order over per-layer valid/ready pairs and muxes the shared weight-ROM address from the active layer.
- Captures the final-layer class scores, then performs a sequential argmax so the winning class index is available alongside the raw scores.
- Sits between the host handshake and the layer engines (ConvLayer, Full_Connect_Layer and successors).

---
 rtl/acc_layer_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_acc_layer_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// acc_layer_sequencer
//
// Top-level sequencer for the CNN accelerator. Runs NUM_LAYERS compute layers
// in order over per-layer valid/ready pairs. It muxes the shared weight-ROM
// address from the active layer and captures the final-layer class scores.
// It then runs a sequential signed argmax, one class per cycle, so the winning
// class index is presented alongside the raw scores.
//
// Optional feature: define ACC_SEQ_TIMEOUT_EN to build a per-layer watchdog.
// The watchdog aborts the run to DONE with err_o=1 after TIMEOUT_CYCLES cycles
// without the active layer's ready.
//
// Ports:
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   acc_valid_i      : host start request, level-held
//   acc_ready_o      : run finished, held until acc_valid_i falls
//   layer_valid_o    : one-hot start for the active layer
//   layer_ready_i    : per-layer completion
//   layer_wt_addr_i  : packed per-layer weight addresses (slice k = layer k)
//   wt_ram_addr_o    : weight ROM address of the active layer
//   score_i          : final-layer scores (slice k = class k, signed)
//   score_o          : captured scores
//   class_o          : argmax class index
//   class_valid_o    : class_o/score_o belong to a completed run
//   layer_idx_o      : current layer index
//   busy_o           : high while running layers or scanning
//   err_o            : watchdog abort flag
// ---------------------------------------------------------------------------
module acc_layer_sequencer #(
    parameter int NUM_LAYERS     = 3,
    parameter int NUM_CLASSES    = 10,
    parameter int SCORE_W        = 8,
    parameter int WT_AW          = 9,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CLS_W         = $clog2(NUM_CLASSES),
    localparam int LI_W          = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           acc_valid_i,
    output logic                           acc_ready_o,
    output logic [NUM_LAYERS-1:0]          layer_valid_o,
    input  logic [NUM_LAYERS-1:0]          layer_ready_i,
    input  logic [NUM_LAYERS*WT_AW-1:0]    layer_wt_addr_i,
    output logic [WT_AW-1:0]               wt_ram_addr_o,
    input  logic [NUM_CLASSES*SCORE_W-1:0] score_i,
    output logic [NUM_CLASSES*SCORE_W-1:0] score_o,
    output logic [CLS_W-1:0]               class_o,
    output logic                           class_valid_o,
    output logic [LI_W-1:0]                layer_idx_o,
    output logic                           busy_o,
    output logic                           err_o
);

    // Elaboration-time sanity check on the configuration.
    if (NUM_LAYERS < 1 || NUM_CLASSES < 2 || SCORE_W < 1 || WT_AW < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("acc_layer_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [LI_W-1:0]                  layer_idx_q, layer_idx_d;
    logic [CLS_W-1:0]                 scan_k_q, scan_k_d;
    logic signed [SCORE_W-1:0]        best_q, best_d;
    logic [CLS_W-1:0]                 bidx_q, bidx_d;
    logic [CLS_W-1:0]                 class_q, class_d;
    logic [NUM_CLASSES*SCORE_W-1:0]   score_q, score_d;
    logic                             acc_ready_q, acc_ready_d;
    logic                             class_valid_q, class_valid_d;
    logic                             err_q, err_d;

    logic                             active_ready;
    logic [WT_AW-1:0]                 wt_addr_mux;
    logic signed [SCORE_W-1:0]        scan_score;
    logic signed [SCORE_W-1:0]        scan_best;
    logic [CLS_W-1:0]                 scan_bidx;
    logic                             wd_expire;

    // Active-layer selection (ready and weight address).
    always_comb begin
        active_ready = 1'b0;
        wt_addr_mux  = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (layer_idx_q == LI_W'(i)) begin
                active_ready = layer_ready_i[i];
                wt_addr_mux  = layer_wt_addr_i[i*WT_AW +: WT_AW];
            end
        end
    end

    // Score under comparison during SCAN.
    always_comb begin
        scan_score = '0;
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            if (scan_k_q == CLS_W'(i)) begin
                scan_score = score_q[i*SCORE_W +: SCORE_W];
            end
        end
    end

`ifdef ACC_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Counter is zero outside RUN, so it is already clear on entering RUN;
    // it also clears on every layer advance.
    always_comb begin
        if (state_q != S_RUN || active_ready) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // Counter value N-1 at an edge means N cycles have elapsed in this layer.
    assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // Strictly-greater signed compare keeps the lowest index on ties.
    always_comb begin
        scan_best = best_q;
        scan_bidx = bidx_q;
        if (scan_score > best_q) begin
            scan_best = scan_score;
            scan_bidx = scan_k_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        layer_idx_d   = layer_idx_q;
        scan_k_d      = scan_k_q;
        best_d        = best_q;
        bidx_d        = bidx_q;
        class_d       = class_q;
        score_d       = score_q;
        acc_ready_d   = acc_ready_q;
        class_valid_d = class_valid_q;
        err_d         = err_q;

        case (state_q)
            S_IDLE: begin
                if (acc_valid_i) begin
                    state_d       = S_RUN;
                    layer_idx_d   = '0;
                    class_valid_d = 1'b0;
                    err_d         = 1'b0;
                end
            end
            S_RUN: begin
                if (active_ready) begin
                    if (layer_idx_q == LI_W'(NUM_LAYERS - 1)) begin
                        // Capture scores and seed the argmax with class 0.
                        state_d  = S_SCAN;
                        score_d  = score_i;
                        best_d   = score_i[SCORE_W-1:0];
                        bidx_d   = '0;
                        scan_k_d = CLS_W'(1);
                    end else begin
                        layer_idx_d = layer_idx_q + 1'b1;
                    end
                end else if (wd_expire) begin
                    state_d       = S_DONE;
                    acc_ready_d   = 1'b1;
                    class_valid_d = 1'b0;
                    err_d         = 1'b1;
                end
            end
            S_SCAN: begin
                best_d   = scan_best;
                bidx_d   = scan_bidx;
                scan_k_d = scan_k_q + 1'b1;
                if (scan_k_q == CLS_W'(NUM_CLASSES - 1)) begin
                    state_d       = S_DONE;
                    class_d       = scan_bidx;
                    acc_ready_d   = 1'b1;
                    class_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!acc_valid_i) begin
                    state_d     = S_IDLE;
                    acc_ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            layer_idx_q   <= '0;
            scan_k_q      <= '0;
            best_q        <= '0;
            bidx_q        <= '0;
            class_q       <= '0;
            score_q       <= '0;
            acc_ready_q   <= 1'b0;
            class_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            layer_idx_q   <= layer_idx_d;
            scan_k_q      <= scan_k_d;
            best_q        <= best_d;
            bidx_q        <= bidx_d;
            class_q       <= class_d;
            score_q       <= score_d;
            acc_ready_q   <= acc_ready_d;
            class_valid_q <= class_valid_d;
            err_q         <= err_d;
        end
    end

    assign layer_valid_o = (state_q == S_RUN) ? (NUM_LAYERS'(1) << layer_idx_q) : '0;
    assign wt_ram_addr_o = wt_addr_mux;
    assign score_o       = score_q;
    assign class_o       = class_q;
    assign class_valid_o = class_valid_q;
    assign acc_ready_o   = acc_ready_q;
    assign layer_idx_o   = layer_idx_q;
    assign busy_o        = (state_q == S_RUN) || (state_q == S_SCAN);
    assign err_o         = err_q;

endmodule

// File: tb/tb_acc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acc_layer_sequencer
//
// Directed bench for acc_layer_sequencer. Each run pushes its expected class
// and scores to a scoreboard queue when the stimulus is driven. The entry is
// popped and compared when acc_ready_o rises.
// ---------------------------------------------------------------------------
module tb_acc_layer_sequencer;

    localparam int NL    = 3;
    localparam int NC    = 10;
    localparam int SW    = 8;
    localparam int AW    = 9;
    localparam int TO    = 16;
    localparam int CLS_W = 4;
    localparam int LI_W  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                acc_valid_i;
    logic                acc_ready_o;
    logic [NL-1:0]       layer_valid_o;
    logic [NL-1:0]       layer_ready_i;
    logic [NL*AW-1:0]    layer_wt_addr_i;
    logic [AW-1:0]       wt_ram_addr_o;
    logic [NC*SW-1:0]    score_i;
    logic [NC*SW-1:0]    score_o;
    logic [CLS_W-1:0]    class_o;
    logic                class_valid_o;
    logic [LI_W-1:0]     layer_idx_o;
    logic                busy_o;
    logic                err_o;

    always #5 clk = ~clk;

    acc_layer_sequencer #(
        .NUM_LAYERS     (NL),
        .NUM_CLASSES    (NC),
        .SCORE_W        (SW),
        .WT_AW          (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .acc_valid_i     (acc_valid_i),
        .acc_ready_o     (acc_ready_o),
        .layer_valid_o   (layer_valid_o),
        .layer_ready_i   (layer_ready_i),
        .layer_wt_addr_i (layer_wt_addr_i),
        .wt_ram_addr_o   (wt_ram_addr_o),
        .score_i         (score_i),
        .score_o         (score_o),
        .class_o         (class_o),
        .class_valid_o   (class_valid_o),
        .layer_idx_o     (layer_idx_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    typedef struct {
        logic [CLS_W-1:0] cls;
        logic [NC*SW-1:0] scores;
    } exp_t;

    exp_t             sb_q[$];
    int               checks = 0;
    int               errors = 0;
    int               cur_sc[NC];
    logic [AW-1:0]    wt_exp[NL];
    logic [NC*SW-1:0] last_scores = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*SW-1:0] pack_cur();
        logic [NC*SW-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*SW +: SW] = SW'(cur_sc[i]);
        return r;
    endfunction

    function automatic int model_argmax();
        int b;
        b = 0;
        for (int i = 1; i < NC; i++) if (cur_sc[i] > cur_sc[b]) b = i;
        return b;
    endfunction

    task automatic randomize_scores();
        for (int i = 0; i < NC; i++) cur_sc[i] = int'($urandom_range(255, 0)) - 128;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        acc_valid_i   = 1'b0;
        layer_ready_i = '0;
        step();
        rst = 1'b0;
        chk("rst_acc_ready",   acc_ready_o,   0);
        chk("rst_layer_valid", layer_valid_o, 0);
        chk("rst_class",       class_o,       0);
        chk("rst_score",       score_o,       0);
        chk("rst_class_valid", class_valid_o, 0);
        chk("rst_layer_idx",   layer_idx_o,   0);
        chk("rst_busy",        busy_o,        0);
        chk("rst_err",         err_o,         0);
        last_scores = '0;
    endtask

    // mode 0: full run; 1: reset during layer 1; 2: reset during SCAN;
    // 3: layer 1 never readies (watchdog / indefinite wait).
    task automatic do_run(input int exp_cls, input int mode, input bit hold);
        exp_t          e;
        int            n;
        logic [NL-1:0] vexp;
        score_i = pack_cur();
        if (mode == 0) begin
            e.cls    = CLS_W'(exp_cls);
            e.scores = score_i;
            sb_q.push_back(e);
        end
        acc_valid_i = 1'b1;
        step();
        chk("start_class_valid", class_valid_o, 0);
        chk("start_err",         err_o,         0);
        for (int k = 0; k < NL; k++) begin
            vexp = NL'(1) << k;
            chk("layer_valid", layer_valid_o, vexp);
            chk("layer_idx",   layer_idx_o,   k);
            chk("wt_addr",     wt_ram_addr_o, wt_exp[k]);
            chk("run_busy",    busy_o,        1);
            if (mode == 1 && k == 1) begin
                do_reset();
                return;
            end
            if (mode == 3 && k == 1) begin
`ifdef ACC_SEQ_TIMEOUT_EN
                n = 0;
                while (acc_ready_o !== 1'b1 && n < 100) begin
                    step();
                    n++;
                end
                chk("timeout_cycles",      n,             TO);
                chk("timeout_err",         err_o,         1);
                chk("timeout_class_valid", class_valid_o, 0);
                chk("timeout_busy",        busy_o,        0);
                chk("timeout_scores_kept", score_o,       last_scores);
                acc_valid_i = 1'b0;
                step();
                chk("timeout_idle_err",    err_o,         1);
                chk("timeout_idle_ready",  acc_ready_o,   0);
`else
                repeat (10000) step();
                chk("nowd_busy",      busy_o,        1);
                chk("nowd_layer_idx", layer_idx_o,   1);
                chk("nowd_err",       err_o,         0);
                chk("nowd_ready",     acc_ready_o,   0);
                chk("nowd_valid",     layer_valid_o, vexp);
                do_reset();
`endif
                return;
            end
            for (int w = 0; w < 5; w++) begin
                // Stray completion from an inactive layer while layer 0 runs.
                layer_ready_i = (k == 0 && w == 1) ? NL'(4) : '0;
                step();
            end
            layer_ready_i = '0;
            chk("layer_hold", layer_valid_o, vexp);
            layer_ready_i = vexp;
            step();
            layer_ready_i = '0;
        end
        n = 1;
        chk("scan_busy",        busy_o,        1);
        chk("scan_ready",       acc_ready_o,   0);
        chk("scan_layer_valid", layer_valid_o, 0);
        if (mode == 2) begin
            repeat (3) step();
            do_reset();
            return;
        end
        while (acc_ready_o !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("ready_latency", n, NC);
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("class",            class_o,       e.cls);
            chk("scores",           score_o,       e.scores);
            chk("done_class_valid", class_valid_o, 1);
            chk("done_busy",        busy_o,        0);
            chk("done_err",         err_o,         0);
            last_scores = e.scores;
            if (hold) begin
                repeat (5) step();
                chk("hold_ready",      acc_ready_o,   1);
                chk("hold_no_restart", layer_valid_o, 0);
                chk("hold_busy",       busy_o,        0);
            end
            acc_valid_i = 1'b0;
            step();
            chk("idle_ready",       acc_ready_o,   0);
            chk("idle_class_valid", class_valid_o, 1);
            chk("idle_busy",        busy_o,        0);
            chk("idle_class_hold",  class_o,       e.cls);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst           = 1'b1;
        acc_valid_i   = 1'b0;
        layer_ready_i = '0;
        score_i       = '0;
        wt_exp[0]     = 9'h010;
        wt_exp[1]     = 9'h120;
        wt_exp[2]     = 9'h1FF;
        layer_wt_addr_i = {wt_exp[2], wt_exp[1], wt_exp[0]};
        step();
        do_reset();

        // Basic run with a tie between classes 2 and 5.
        cur_sc = '{3, -7, 12, 0, 5, 12, -128, 1, 2, 9};
        do_run(2, 0, 1'b1);

        // Negative scores: -1 must beat -100 under signed compare.
        for (int i = 0; i < NC; i++) cur_sc[i] = -100;
        cur_sc[9] = -1;
        do_run(9, 0, 1'b0);

        // Reset during layer 1, then during SCAN.
        randomize_scores();
        do_run(0, 1, 1'b0);
        randomize_scores();
        do_run(0, 2, 1'b0);

        // Fresh start after reset, random scores.
        randomize_scores();
        do_run(model_argmax(), 0, 1'b0);

        // Layer 1 never completes.
        randomize_scores();
        do_run(0, 3, 1'b0);

        // Recovery run.
        randomize_scores();
        do_run(model_argmax(), 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
